// File: rtl/nios_pio_out_pkg.sv
// Shared register map and reset constants for the Nios output PIO.
package nios_pio_out_pkg;

  localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
  localparam logic [2:0] PIO_ADDR_SET       = 3'd1;
  localparam logic [2:0] PIO_ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] PIO_ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] PIO_ADDR_PULSE     = 3'd4;
  localparam logic [2:0] PIO_ADDR_PULSE_LEN = 3'd5;

  localparam int unsigned PIO_PULSE_LEN_RST = 1;

endpackage

// File: rtl/nios_pio_pulse_timer.sv
// Retriggerable one-shot: arming ORs bits into the mask and reloads the
// down-counter; the mask clears on the 1->0 count transition.
module nios_pio_pulse_timer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_arm_bits,
  input  logic [CNT_W-1:0]  i_len,
  output logic [DATA_W-1:0] o_mask
);

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mask;
  logic [CNT_W-1:0]  w_load;

  // A programmed length of zero still yields a one-cycle pulse.
  assign w_load = (i_len == '0) ? CNT_W'(1) : i_len;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_mask  <= '0;
    end else if (i_arm) begin
      // Arming wins over a simultaneous expiry, keeping all live bits.
      r_mask  <= r_mask | i_arm_bits;
      r_count <= w_load;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) begin
        r_mask <= '0;
      end
    end
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/nios_system_pio_out.sv
// Avalon-MM output PIO with atomic set/clear/toggle and an optional one-shot
// pulse channel, built only when NIOS_PIO_OUT_PULSE_EN is defined.
module nios_system_pio_out
  import nios_pio_out_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port
);

  logic              w_wr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] r_data;
  logic              w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wdata  = writedata[DATA_W-1:0];
  assign w_unused = &{1'b0, writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (address)
        PIO_ADDR_DATA:   r_data <= w_wdata;
        PIO_ADDR_SET:    r_data <= r_data | w_wdata;
        PIO_ADDR_CLEAR:  r_data <= r_data & ~w_wdata;
        PIO_ADDR_TOGGLE: r_data <= r_data ^ w_wdata;
        default:         r_data <= r_data;
      endcase
    end
  end

`ifdef NIOS_PIO_OUT_PULSE_EN
  logic [CNT_W-1:0] r_pulse_len;
  logic             w_arm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse_len <= CNT_W'(PIO_PULSE_LEN_RST);
    end else if (w_wr && (address == PIO_ADDR_PULSE_LEN)) begin
      r_pulse_len <= writedata[CNT_W-1:0];
    end
  end

  assign w_arm = w_wr && (address == PIO_ADDR_PULSE) && (w_wdata != '0);

  nios_pio_pulse_timer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_pulse_timer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_arm      (w_arm),
    .i_arm_bits (w_wdata),
    .i_len      (r_pulse_len),
    .o_mask     (w_mask)
  );
`else
  assign w_mask = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:      readdata[DATA_W-1:0] = r_data;
`ifdef NIOS_PIO_OUT_PULSE_EN
      PIO_ADDR_PULSE:     readdata[DATA_W-1:0] = w_mask;
      PIO_ADDR_PULSE_LEN: readdata[CNT_W-1:0]  = r_pulse_len;
`endif
      default:            readdata = '0;
    endcase
  end

  assign out_port = r_data | w_mask;

endmodule

// File: tb/tb_nios_system_pio_out.sv
// Self-checking bench for nios_system_pio_out; covers both builds of
// NIOS_PIO_OUT_PULSE_EN using a per-bit expiry-time model of the pulses.
module tb_nios_system_pio_out;

`ifdef NIOS_PIO_OUT_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif
  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_errors = 0;

  nios_system_pio_out #(
    .DATA_W      (8),
    .RESET_VALUE (RV),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Model: each pulse bit is high while the cycle number is below its expiry.
  int unsigned m_cyc = 0;
  int unsigned m_end [8];
  logic [7:0]  m_data;
  logic [15:0] m_len;

  function automatic logic [7:0] m_mask();
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++) if (m_cyc < m_end[b]) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_data};
      3'd4:    return PULSE_EN ? {24'h0, m_mask()} : 32'h0;
      3'd5:    return PULSE_EN ? {16'h0, m_len} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data = RV;
      m_len  = 16'd1;
      for (int b = 0; b < 8; b++) m_end[b] = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd1: m_data = m_data | writedata[7:0];
          3'd2: m_data = m_data & ~writedata[7:0];
          3'd3: m_data = m_data ^ writedata[7:0];
          3'd4: if (PULSE_EN && writedata[7:0] != 8'h0) begin
            int unsigned len;
            len = (m_len == 16'd0) ? 1 : int'(m_len);
            for (int b = 0; b < 8; b++)
              if (m_end[b] >= m_cyc || writedata[b]) m_end[b] = m_cyc + len;
          end
          3'd5: if (PULSE_EN) m_len = writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_out", {24'h0, out_port}, {24'h0, m_data | m_mask()});
    check("model_rd", readdata, m_rd(address));
  end

  // Tasks assume they start just after a rising edge and return the same way.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a; #1;
    check(name, readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {24'h0, out_port}, 32'hA5);
    reset = 1'b0;
    rd_check("rst_data", 3'd0, 32'hA5);
    rd_check("rst_pulse", 3'd4, 32'h0);
    rd_check("rst_len", 3'd5, PULSE_EN ? 32'h1 : 32'h0);
    idle(1);

    do_write(3'd0, 32'hFFFF_FF0F);
    check("data_out", {24'h0, out_port}, 32'h0F);
    rd_check("data_rd", 3'd0, 32'h0F);
    do_write(3'd1, 32'h30);
    check("set_out", {24'h0, out_port}, 32'h3F);
    rd_check("set_rd", 3'd0, 32'h3F);
    rd_check("set_reads0", 3'd1, 32'h0);
    do_write(3'd2, 32'h03);
    check("clr_out", {24'h0, out_port}, 32'h3C);
    rd_check("clr_rd", 3'd0, 32'h3C);
    address = 3'd3; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0; #1;
    check("tog_before_edge", {24'h0, out_port}, 32'h3C);
    @(posedge clk); #1; chipselect = 1'b0; write_n = 1'b1;
    check("tog_out", {24'h0, out_port}, 32'hC3);
    rd_check("tog_rd", 3'd0, 32'hC3);
    rd_check("tog_reads0", 3'd3, 32'h0);

    do_write(3'd6, 32'hFF);
    rd_check("rsv6_rd", 3'd6, 32'h0);
    check("rsv6_out", {24'h0, out_port}, 32'hC3);

    if (PULSE_EN) begin
      do_write(3'd0, 32'h0);
      do_write(3'd5, 32'h3);
      rd_check("len_rd", 3'd5, 32'h3);
      do_write(3'd4, 32'h01);
      rd_check("pulse_rd_active", 3'd4, 32'h01);
      ones = 0;
      for (int i = 0; i < 6; i++) begin
        if (out_port[0]) ones++;
        idle(1);
      end
      check("pulse3_len", ones, 3);
      rd_check("pulse_rd_after", 3'd4, 32'h00);

      do_write(3'd5, 32'h4);
      do_write(3'd4, 32'h01);
      check("retrig_a0", {24'h0, out_port}, 32'h01);
      idle(1);
      check("retrig_a1", {24'h0, out_port}, 32'h01);
      do_write(3'd4, 32'h02);
      for (int i = 0; i < 4; i++) begin
        check("retrig_both", {24'h0, out_port}, 32'h03);
        idle(1);
      end
      check("retrig_end", {24'h0, out_port}, 32'h00);

      do_write(3'd5, 32'h3);
      do_write(3'd4, 32'h04);
      idle(2);
      do_write(3'd4, 32'h08);
      for (int i = 0; i < 3; i++) begin
        check("expiry_ext", {24'h0, out_port}, 32'h0C);
        idle(1);
      end
      check("expiry_end", {24'h0, out_port}, 32'h00);

      do_write(3'd4, 32'h40);
      do_write(3'd5, 32'h6);
      check("len_mid_a", {24'h0, out_port}, 32'h40);
      idle(1);
      check("len_mid_b", {24'h0, out_port}, 32'h40);
      idle(1);
      check("len_mid_end", {24'h0, out_port}, 32'h00);
      do_write(3'd4, 32'h80);
      ones = 0;
      for (int i = 0; i < 9; i++) begin
        if (out_port[7]) ones++;
        idle(1);
      end
      check("len6_next_arm", ones, 6);

      do_write(3'd4, 32'h00);
      check("zero_arm", {24'h0, out_port}, 32'h00);
      do_write(3'd5, 32'h0);
      do_write(3'd4, 32'h20);
      check("len0_a", {24'h0, out_port}, 32'h20);
      idle(1);
      check("len0_end", {24'h0, out_port}, 32'h00);

      do_write(3'd5, 32'h5);
      do_write(3'd4, 32'h10);
      #3 reset = 1'b1;
      #1 check("rst_mid_out", {24'h0, out_port}, 32'hA5);
      idle(2);
      reset = 1'b0;
      rd_check("rst_mid_pulse", 3'd4, 32'h0);
      rd_check("rst_mid_len", 3'd5, 32'h1);
      idle(6);
      check("rst_mid_after", {24'h0, out_port}, 32'hA5);
    end else begin
      do_write(3'd4, 32'hFF);
      rd_check("rsv4_rd", 3'd4, 32'h0);
      check("rsv4_out", {24'h0, out_port}, 32'hC3);
      do_write(3'd5, 32'h7);
      rd_check("rsv5_rd", 3'd5, 32'h0);
      check("rsv5_out", {24'h0, out_port}, 32'hC3);
      idle(1);
      #3 reset = 1'b1;
      #1 check("rst_mid_out", {24'h0, out_port}, 32'hA5);
      idle(2);
      reset = 1'b0;
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_out.md
# nios_system_pio_out

Parametrised Avalon-MM output PIO for the Nios II system. It drives a `DATA_W`-bit `out_port` and generalises the fixed 3-bit state port to configurable width and reset value. It adds atomic set/clear/toggle writes and a retriggerable one-shot pulse channel, so software can strobe board signals without read-modify-write races. It sits on the Nios data master as a zero-wait-state slave.

## Interface
- `DATA_W`, 8, output width, 1..32
- `RESET_VALUE`, 0, value of the data register after reset, `DATA_W` bits
- `CNT_W`, 16, pulse-length counter width, 1..32

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `address` in 3: word address of the register
- `chipselect` in 1: slave select
- `write_n` in 1: active-low write strobe
- `writedata` in 32: write data; bits above `DATA_W`/`CNT_W` ignored
- `readdata` out 32: combinational read data, zero-extended
- `out_port` out `DATA_W`: registered output, `data_reg | pulse_mask`

## Operation
- Write strobe `wr = chipselect & ~write_n`. There is no read strobe; reads have no side effects.
- Register map:
  - 0 DATA: read/write.
  - 1 SET: write ORs into DATA.
  - 2 CLEAR: write ANDs DATA with the inverted write data.
  - 3 TOGGLE: write XORs into DATA.
  - 4 PULSE: write arms a pulse; read returns `pulse_mask`.
  - 5 PULSE_LEN: read/write, `CNT_W` bits.
  - 6–7: reads return 0, writes are ignored.
- SET, CLEAR and TOGGLE read as 0.
- Pulse channel:
  - A write to PULSE with nonzero `writedata[DATA_W-1:0]` sets `pulse_mask <= pulse_mask | wdata` and `count <= max(PULSE_LEN,1)`.
  - A write of all-zero data has no effect.
  - While `count != 0`, `count` decrements each cycle. On the cycle it goes 1→0, `pulse_mask <= 0`.
  - Result: each bit is high on `out_port` for exactly `max(PULSE_LEN,1)` cycles after the last arming write.
- Retrigger: a PULSE write while active reloads `count` and ORs in the new bits, so all active bits are extended.
- Simultaneous PULSE write and expiry: the write wins. The mask becomes old|new and the count reloads.
- A PULSE_LEN write during an active pulse does not affect the running `count`. It applies to the next arm.
- Pulse bits OR over DATA. Bits high in DATA stay high after expiry.

## Timing
- Writes take effect on the rising `clk` edge where `wr` is high. `out_port` reflects the new value in the following cycle (1-cycle latency).
- Reads are zero-wait-state: `readdata` is a combinational function of `address` and the current registers.
- Pulse example, PULSE_LEN=3:
  - Write at edge N.
  - `out_port` bit high in cycles N+1..N+3.
  - Bit low from N+4.
- Reset (asynchronous assert, synchronous release to `clk`):
  - DATA = `RESET_VALUE`
  - `pulse_mask` = 0
  - `count` = 0
  - PULSE_LEN = 1
  - `out_port` = `RESET_VALUE`
- Reset mid-pulse aborts the pulse immediately.
- Counter arithmetic is unsigned `CNT_W`. It never decrements below 0.

## Configuration
- `NIOS_PIO_OUT_PULSE_EN` defined: the pulse channel is built as described above.
- Not defined:
  - `pulse_mask`, `count` and PULSE_LEN are removed.
  - Addresses 4–5 behave as reserved: they read 0 and ignore writes.
  - `out_port` equals DATA.

## Structure
- Shared package `nios_pio_out_pkg` holds:
  - the register address localparams `PIO_ADDR_DATA`..`PIO_ADDR_PULSE_LEN`;
  - the PULSE_LEN reset constant (1).
- Sub-module `nios_pio_pulse_timer` contains the `count` load/decrement and the mask-clear logic. It is parametrised by `DATA_W` and `CNT_W`.
- The top level contains only the register decode and the read mux.

## Test plan
- Reset with `RESET_VALUE`=8'hA5 -> `out_port`=A5, DATA reads A5, PULSE reads 0, PULSE_LEN reads 1.
- Write DATA=0x0F, SET 0x30, CLEAR 0x03, TOGGLE 0xFF -> DATA reads 0x0F, then 0x3F, then 0x3C, then 0xC3. Each value appears on `out_port` one cycle after its write.
- PULSE_LEN=3, DATA=0, PULSE 0x01 -> bit0 high exactly 3 cycles, then 0. PULSE reads 0x01 during the pulse and 0x00 after.
- PULSE 0x01, then PULSE 0x02 two cycles later with PULSE_LEN=4 -> `out_port`=0x03 for 4 cycles after the second write, then 0x00. Bit0 is high for 6 cycles in total.
- PULSE written on the exact cycle `count`==1 -> no gap on `out_port`. The pulse is extended by a full PULSE_LEN.
- `reset` asserted mid-pulse, asynchronously to `clk` -> `out_port` goes to `RESET_VALUE` before the next edge. Separately, with the macro undefined, a write to address 4 gives `readdata`=0 and `out_port` unchanged.
